// File: rtl/data_ram_bist_pkg.sv
// Shared types and March C- element constants for the data_ram BIST engine.
package data_ram_bist_pkg;

   localparam logic [31:0] BIST_PAT_DEFAULT = 32'hA5A5_5A5A;

   typedef enum logic [2:0] {
      IDLE,
      W0,
      U01,
      U10,
      D01,
      D10,
      R0,
      FIN
   } state_e;

   // down: idx runs DEPTH-1 -> 0; rd_first: element opens with a read;
   // exp_one: read expects ~PAT; wr_one: write stores ~PAT.
   typedef struct packed {
      logic down;
      logic rd_first;
      logic exp_one;
      logic wr_one;
   } elem_t;

   function automatic elem_t elem_info(state_e s);
      elem_t e;
      e = '{down: 1'b0, rd_first: 1'b0, exp_one: 1'b0, wr_one: 1'b0};
      case (s)
         U01:     e = '{down: 1'b0, rd_first: 1'b1, exp_one: 1'b0, wr_one: 1'b1};
         U10:     e = '{down: 1'b0, rd_first: 1'b1, exp_one: 1'b1, wr_one: 1'b0};
         D01:     e = '{down: 1'b1, rd_first: 1'b1, exp_one: 1'b0, wr_one: 1'b1};
         D10:     e = '{down: 1'b1, rd_first: 1'b1, exp_one: 1'b1, wr_one: 1'b0};
         R0:      e = '{down: 1'b0, rd_first: 1'b1, exp_one: 1'b0, wr_one: 1'b0};
         default: e = '{down: 1'b0, rd_first: 1'b0, exp_one: 1'b0, wr_one: 1'b0};
      endcase
      return e;
   endfunction

   // Element that follows a two-operation element.
   function automatic state_e next_elem(state_e s);
      state_e n;
      case (s)
         U01:     n = U10;
         U10:     n = D01;
         D01:     n = D10;
         D10:     n = R0;
         default: n = IDLE;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/data_ram_bist_addr_gen.sv
// Loadable up/down word index with terminal-count flag and byte-address output.
module bist_addr_gen #(
   parameter int unsigned DEPTH = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic        load_top,
   input  logic        step,
   input  logic        down,
   output logic        last,
   output logic [31:0] addr
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW-1:0] TOP = AW'(DEPTH - 1);

   logic [AW-1:0] idx;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx <= '0;
      end else if (load) begin
         idx <= load_top ? TOP : '0;
      end else if (step) begin
         idx <= down ? idx - AW'(1) : idx + AW'(1);
      end
   end

   // Terminal index depends on the direction of the running element.
   assign last = down ? (idx == '0) : (idx == TOP);
   assign addr = 32'(idx) << 2;

endmodule

// File: rtl/data_ram_bist.sv
// March C- BIST initiator for data_ram: sequencing FSM, read comparator and
// first-failure latches; the index counter lives in bist_addr_gen.
module data_ram_bist
   import data_ram_bist_pkg::*;
#(
   parameter int unsigned   DEPTH = 1024,
   parameter int unsigned   DW    = 32,
   parameter logic [DW-1:0] PAT   = DW'(BIST_PAT_DEFAULT)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic          pass,
   output logic [31:0]   err_addr,
   output logic [DW-1:0] err_data,
   output logic          WE,
   output logic          RE,
   output logic [31:0]   A,
   output logic [DW-1:0] WD,
   input  logic [DW-1:0] RD
);

   state_e        state;
   state_e        state_n;
   logic          ld;
   logic          ld_top;
   logic          step;
   logic          dir_down;
   logic          last;
   logic          adv;
   logic          mismatch;
   logic          fin_pass;
   logic          we_n;
   logic          re_n;
   logic [DW-1:0] wd_n;
   logic [DW-1:0] rd_exp;

   bist_addr_gen #(.DEPTH(DEPTH)) u_addr_gen (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (ld),
      .load_top (ld_top),
      .step     (step),
      .down     (dir_down),
      .last     (last),
      .addr     (A)
   );

   // Next state plus next-cycle RAM command; a read cycle is recognised by RE.
   always_comb begin
      state_n  = state;
      ld       = 1'b0;
      ld_top   = 1'b0;
      step     = 1'b0;
      adv      = 1'b0;
      mismatch = 1'b0;
      fin_pass = 1'b0;
      we_n     = 1'b0;
      re_n     = 1'b0;
      wd_n     = '0;
      dir_down = elem_info(state).down;
      rd_exp   = elem_info(state).exp_one ? ~PAT : PAT;

      case (state)
         IDLE: begin
            if (start) begin
               state_n = W0;
               ld      = 1'b1;
               adv     = 1'b1;
            end
         end
         W0: begin
            adv = 1'b1;
            if (last) begin
               state_n = U01;
               ld      = 1'b1;
            end else begin
               step = 1'b1;
            end
         end
         U01, U10, D01, D10: begin
            if (RE) begin
               if (RD != rd_exp) begin
                  mismatch = 1'b1;
                  state_n  = FIN;
               end else begin
                  we_n = 1'b1;
               end
            end else begin
               adv = 1'b1;
               if (last) begin
                  state_n = next_elem(state);
                  ld      = 1'b1;
               end else begin
                  step = 1'b1;
               end
            end
         end
         R0: begin
            if (RD != rd_exp) begin
               mismatch = 1'b1;
               state_n  = FIN;
            end else if (last) begin
               fin_pass = 1'b1;
               state_n  = FIN;
            end else begin
               step = 1'b1;
               adv  = 1'b1;
            end
         end
         FIN:     state_n = IDLE;
         default: state_n = IDLE;
      endcase

      ld_top = elem_info(state_n).down;
      if (adv) begin
         re_n = elem_info(state_n).rd_first;
         we_n = ~elem_info(state_n).rd_first;
      end
      if (we_n) begin
         wd_n = elem_info(state_n).wr_one ? ~PAT : PAT;
      end
   end

   // State, registered port outputs and first-failure latches.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         pass     <= 1'b0;
         err_addr <= '0;
         err_data <= '0;
         WE       <= 1'b0;
         RE       <= 1'b0;
         WD       <= '0;
      end else begin
         state <= state_n;
         busy  <= (state_n != IDLE) && (state_n != FIN);
         done  <= (state_n == FIN);
         WE    <= we_n;
         RE    <= re_n;
         WD    <= wd_n;
         if ((state == IDLE) && start) begin
            pass     <= 1'b0;
            err_addr <= '0;
            err_data <= '0;
         end
         if (mismatch) begin
            err_addr <= A;
            err_data <= RD;
         end
         if (fin_pass) begin
            pass <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_data_ram_bist.sv
// Self-checking bench for data_ram_bist: fault-injecting RAM model, March C-
// reference trace built from the algorithm, per-cycle compare and protocol monitor.
module tb_data_ram_bist;

   localparam int          DEPTH = 16;
   localparam logic [31:0] PAT   = 32'hA5A5_5A5A;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        busy;
   logic        done;
   logic        pass;
   logic [31:0] err_addr;
   logic [31:0] err_data;
   logic        WE;
   logic        RE;
   logic [31:0] A;
   logic [31:0] WD;
   logic [31:0] RD;

   typedef struct {
      logic        we;
      logic        re;
      logic [31:0] a;
      logic [31:0] wd;
   } op_t;

   typedef struct {
      logic        busy;
      logic        done;
      logic        we;
      logic        re;
      logic        chk_a;
      logic        chk_wd;
      logic        chk_res;
      logic        pass;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] ea;
      logic [31:0] ed;
   } cyc_t;

   op_t         mq[$];
   cyc_t        xq[$];
   logic [31:0] mem[DEPTH];
   logic [31:0] mm[DEPTH];
   int          wcnt[DEPTH];
   int          wbase[DEPTH];
   int          ncmp = 0;
   int          nerr = 0;
   int unsigned fk;
   logic [3:0]  fa;
   logic [3:0]  fvic;
   logic [4:0]  fb;
   logic        fv;
   logic        m_pass;
   logic [31:0] m_ea;
   logic [31:0] m_ed;
   logic        mon_on;
   logic [31:0] rd_v;

   data_ram_bist #(.DEPTH(DEPTH), .DW(32), .PAT(PAT)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .busy     (busy),
      .done     (done),
      .pass     (pass),
      .err_addr (err_addr),
      .err_data (err_data),
      .WE       (WE),
      .RE       (RE),
      .A        (A),
      .WD       (WD),
      .RD       (RD)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM with optional stuck-at bit (fk=1) or write coupling fa->fvic (fk=2).
   always @(posedge clk) begin
      if (WE) begin
         mem[A[5:2]] <= WD;
         if (fk == 2 && A[5:2] == fa) mem[fvic] <= WD;
      end
   end

   always_comb begin
      rd_v = mem[A[5:2]];
      if (fk == 1 && A[5:2] == fa) rd_v[fb] = fv;
      RD = RE ? rd_v : 32'h0;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h want %h at t=%0t", nm, act, exp, $time);
      end
   endtask

   // Reference memory model with the same fault behaviour as the RAM.
   task automatic m_write(input logic [3:0] i, input logic [31:0] v);
      mq.push_back('{we: 1'b1, re: 1'b0, a: {26'b0, i, 2'b00}, wd: v});
      mm[i] = v;
      if (fk == 2 && i == fa) mm[fvic] = v;
   endtask

   task automatic m_read(input logic [3:0] i, input logic [31:0] expv);
      logic [31:0] got;
      got = mm[i];
      if (fk == 1 && i == fa) got[fb] = fv;
      mq.push_back('{we: 1'b0, re: 1'b1, a: {26'b0, i, 2'b00}, wd: 32'h0});
      if (got !== expv) begin
         m_pass = 1'b0;
         m_ea   = {26'b0, i, 2'b00};
         m_ed   = got;
      end
   endtask

   // March C-: w0; up(r0,w1); up(r1,w0); down(r0,w1); down(r1,w0); up(r0). Stops at first bad read.
   task automatic build_expect();
      mq.delete();
      m_pass = 1'b1;
      m_ea   = 32'h0;
      m_ed   = 32'h0;
      foreach (mm[k]) mm[k] = 32'h0;
      for (int k = 0; k < DEPTH; k++) m_write(4'(k), PAT);
      for (int e = 0; e < 4 && m_pass; e++) begin
         for (int k = 0; k < DEPTH && m_pass; k++) begin
            logic [3:0] i;
            i = (e >= 2) ? 4'(DEPTH - 1 - k) : 4'(k);
            m_read(i, (e % 2 == 1) ? ~PAT : PAT);
            if (m_pass) m_write(i, (e % 2 == 1) ? PAT : ~PAT);
         end
      end
      for (int k = 0; k < DEPTH && m_pass; k++) m_read(4'(k), PAT);
   endtask

   function automatic void push_cyc(input logic b, d, w, r, ca, cw, cr, p,
                                    input logic [31:0] a, wd, ea, ed);
      cyc_t c;
      c.busy = b;  c.done = d;  c.we = w;   c.re = r;
      c.chk_a = ca; c.chk_wd = cw; c.chk_res = cr; c.pass = p;
      c.a = a; c.wd = wd; c.ea = ea; c.ed = ed;
      xq.push_back(c);
   endfunction

   function automatic void push_op(input op_t o);
      push_cyc(1'b1, 1'b0, o.we, o.re, 1'b1, o.we, 1'b1, 1'b0, o.a, o.wd, 32'h0, 32'h0);
   endfunction

   function automatic void push_fin();
      push_cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, m_pass, 32'h0, 32'h0, m_ea, m_ed);
   endfunction

   function automatic void push_idle(input logic res);
      push_cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, res, m_pass, 32'h0, 32'h0, m_ea, m_ed);
   endfunction

   // Compare process: protocol monitor every cycle plus the expected-cycle queue.
   always @(negedge clk) begin
      cyc_t e;
      if (mon_on) begin
         chk("we_re_exclusive", 32'(WE & RE), 32'h0);
         chk("addr_align", 32'(A[1:0]), 32'h0);
         chk("addr_range", 32'(A >= 32'h40), 32'h0);
         if (WE) wcnt[A[5:2]]++;
      end
      if (xq.size() > 0) begin
         e = xq.pop_front();
         chk("busy", 32'(busy), 32'(e.busy));
         chk("done", 32'(done), 32'(e.done));
         chk("we", 32'(WE), 32'(e.we));
         chk("re", 32'(RE), 32'(e.re));
         if (e.chk_a) chk("addr", A, e.a);
         if (e.chk_wd) chk("wdata", WD, e.wd);
         if (e.chk_res) begin
            chk("pass", 32'(pass), 32'(e.pass));
            chk("err_addr", err_addr, e.ea);
            chk("err_data", err_data, e.ed);
         end
      end
   end

   task automatic drain();
      int n;
      n = 0;
      do begin
         @(posedge clk);
         n++;
      end while (xq.size() != 0 && n < 5000);
      #2;
      chk("drain_timeout", 32'(xq.size()), 32'h0);
      xq.delete();
   endtask

   task automatic do_run(input int poke_at);
      foreach (wbase[k]) wbase[k] = wcnt[k];
      build_expect();
      push_idle(1'b0);
      foreach (mq[j]) push_op(mq[j]);
      push_fin();
      push_idle(1'b1);
      start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
      if (poke_at > 0) begin
         repeat (poke_at - 1) @(posedge clk);
         #2 start = 1'b1;
         @(posedge clk); #2;
         start = 1'b0;
      end
      drain();
      if (m_pass) foreach (wcnt[k]) chk("write_count", 32'(wcnt[k] - wbase[k]), 32'd5);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, summary not printed normally");
      $fatal(1);
   end

   initial begin
      int n;
      rst_n  = 1'b0;
      start  = 1'b0;
      fk     = 0;
      fa     = 4'd0;
      fvic   = 4'd0;
      fb     = 5'd0;
      fv     = 1'b0;
      mon_on = 1'b0;
      m_pass = 1'b0;
      m_ea   = 32'h0;
      m_ed   = 32'h0;
      foreach (wcnt[k]) wcnt[k] = 0;

      // Reset values.
      repeat (3) @(posedge clk);
      #2;
      push_cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
      rst_n  = 1'b1;
      mon_on = 1'b1;
      drain();

      // Fault-free run.
      fk = 0;
      do_run(0);
      chk("model_len_clean", 32'(mq.size()), 32'd160);
      chk("model_pass_clean", 32'(m_pass), 32'd1);

      // Word 5 bit 0 stuck-at-1.
      fk = 1; fa = 4'd5; fb = 5'd0; fv = 1'b1;
      do_run(0);
      chk("model_len_stuck", 32'(mq.size()), 32'd27);
      chk("model_ea_stuck", m_ea, 32'h0000_0014);
      chk("model_ed_stuck", m_ed, 32'hA5A5_5A5B);
      chk("model_pass_stuck", 32'(m_pass), 32'd0);

      // Write to word 2 also writes word 3.
      fk = 2; fa = 4'd2; fvic = 4'd3;
      do_run(0);
      chk("model_len_couple", 32'(mq.size()), 32'd23);
      chk("model_ea_couple", m_ea, 32'h0000_000C);
      chk("model_ed_couple", m_ed, 32'h5A5A_A5A5);

      // start pulsed mid-run is ignored.
      fk = 0;
      do_run(40);

      // start held high through FIN: back-to-back runs with one IDLE cycle between.
      build_expect();
      push_idle(1'b0);
      foreach (mq[j]) push_op(mq[j]);
      push_fin();
      push_idle(1'b1);
      foreach (mq[j]) push_op(mq[j]);
      push_fin();
      push_idle(1'b1);
      start = 1'b1;
      n = 0;
      while (xq.size() > 10 && n < 5000) begin
         @(posedge clk);
         n++;
      end
      #2 start = 1'b0;
      drain();

      // Reset for one edge after 50 busy cycles.
      build_expect();
      push_idle(1'b0);
      for (int j = 0; j < 50; j++) push_op(mq[j]);
      push_cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
      push_cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
      start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
      repeat (49) @(posedge clk);
      #2 rst_n = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b1;
      drain();
      do_run(0);

      // Randomized faults and gaps.
      for (int r = 0; r < 8; r++) begin
         fk   = $urandom_range(0, 2);
         fa   = 4'($urandom_range(0, 15));
         fvic = fa + 4'($urandom_range(1, 15));
         fb   = 5'($urandom_range(0, 31));
         fv   = 1'($urandom_range(0, 1));
         repeat ($urandom_range(0, 5)) @(posedge clk);
         #0;
         do_run((fk == 0 && $urandom_range(0, 1) == 1) ? int'($urandom_range(2, 150)) : 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule

// File: doc/data_ram_bist.md
# data_ram_bist

Built-in self-test engine for `data_ram`: the initiator on the RAM's `WE/RE/A/WD/RD` port. It runs a March C- sequence over every word, checks each read against the expected background, and reports pass/fail with the first failing address and data. It sits beside `data_ram` and owns the RAM port while `busy` is high. System logic muxes the port back when `busy` is low.

## Interface
- `DEPTH`, 1024: number of 32-bit words tested. Power of two, ≥2.
- `DW`, 32: data width.
- `PAT`, 32'hA5A5_5A5A: background pattern, called "0". Its complement `~PAT` is "1".
- `clk` in 1: sole clock. All logic on posedge.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: level-sampled; accepted only in IDLE.
- `busy` out 1: test in progress.
- `done` out 1: one-cycle pulse when the test ends.
- `pass` out 1: result, valid from `done` until the next accepted `start`.
- `err_addr` out 32: byte address of the first mismatch.
- `err_data` out DW: RD value at the first mismatch.
- `WE` out 1: RAM write enable.
- `RE` out 1: RAM read enable.
- `A` out 32: RAM byte address, always `idx<<2`.
- `WD` out DW: RAM write data.
- `RD` in DW: RAM read data, combinational from `A`/`RE` within the same cycle.

## Operation
- States:
  - IDLE
  - W0: ⇑ w0
  - U01: ⇑ r0,w1
  - U10: ⇑ r1,w0
  - D01: ⇓ r0,w1
  - D10: ⇓ r1,w0
  - R0: ⇑ r0
  - FIN
- IDLE → W0 when `start`=1. `idx` is cleared and `pass`, `err_addr`, `err_data` are cleared.
- W0: one write cycle per address (`WE`=1, `WD`=PAT).
- U01, U10, D01, D10: two cycles per address.
  - Read cycle: `RE`=1 and RD is compared at the clock edge.
  - Write cycle: `WE`=1 with the complemented value.
- R0: one read cycle per address.
- Up elements run `idx` 0→DEPTH-1; down elements run DEPTH-1→0. At the last index the FSM moves to the next element, with `idx` preloaded to 0 or DEPTH-1.
- Compare: expected value is PAT for r0 and ~PAT for r1. On mismatch:
  - latch `err_addr`=A and `err_data`=RD;
  - skip the pending write;
  - go directly to FIN with `pass`=0.
- FIN: `done`=1 and `busy`=0 for exactly one cycle. `pass`=1 if no mismatch occurred. Then → IDLE.
- `WE` and `RE` are never both 1. Both are 0 in IDLE and FIN. `A`[1:0]=0 and `A` < 4·DEPTH at all times.
- `start` while busy is ignored. `start` held high in IDLE after FIN starts a new run.

## Timing
- All outputs are registered. Reset values: `busy`=0, `done`=0, `pass`=0, `err_addr`=0, `err_data`=0, `WE`=0, `RE`=0, `A`=0, `WD`=0. State resets to IDLE.
- Edge k samples `start`=1. In cycle k+1: `busy`=1, `WE`=1, `A`=0, `WD`=PAT.
- Fault-free run: `busy` high for exactly 10·DEPTH cycles. `done` rises in the cycle after the final R0 read (`A`=4·(DEPTH-1)).
- Failing run: `done` pulses in the cycle immediately after the mismatching read cycle. `busy` drops in that same cycle.
- Reset mid-run takes effect at the next edge: all outputs return to reset values and no further RAM write occurs.
- Index arithmetic is a log2(DEPTH)-bit counter. Terminal index is detected explicitly; there is no wrap.

## Structure
- `data_ram_bist_pkg`:
  - state enum (IDLE, W0, U01, U10, D01, D10, R0, FIN);
  - `BIST_PAT_DEFAULT`;
  - per-element constants: direction, first op, read expect, write value.
- Sub-module `bist_addr_gen`: loadable up/down index counter with a terminal-count flag and `A=idx<<2` output.
- The top level holds the FSM, comparator and error latches.

## Test plan
- DEPTH=16 with a fault-free `data_ram`, 1-cycle `start` pulse → `busy`=1 for 160 cycles, `done` one pulse, `pass`=1, `err_addr`=0, `err_data`=0.
- Word 5 bit 0 stuck-at-1 → fail in U01 at idx 5: `err_addr`=0x14, `err_data`=0xA5A5_5A5B, `pass`=0, `done` one cycle after that read.
- Write to word 2 also writes word 3 → fail in U01 at idx 3: `err_addr`=0x0C, `err_data`=0x5A5A_A5A5, `pass`=0.
- `start` pulsed at cycle 40 of a run → ignored, still 160 busy cycles. `start` held high through FIN → second run begins the cycle after IDLE is re-entered.
- `rst_n`=0 at cycle 50 for one edge → next cycle `WE`=`RE`=0, `busy`=0, `A`=0. A subsequent `start` completes with `pass`=1.
- Protocol monitor for all runs:
  - never `WE`&`RE` together;
  - `A`[1:0]=0 and `A`<0x40;
  - each word written exactly 5 times in a fault-free run.
